fpga_uart_host_tx: RTL and testbench
====================================

// Module: fpga_uart_host_tx
// PURPOSE
//  Fabric-side UART transmitter acting as the host end of the SoC console on FPGA targets.
//  Drives pad_uart_rx with 8N1 (optionally 8E1) frames from a valid/ready byte stream
//  (boot-command injection, HIL tests, no external USB-UART).
//  Optional hardware flow control: honours the SoC's active-low RTS before each frame.
// PARAMETERS
//  CLKS_PER_BIT  1085  clk_i cycles per bit (125 MHz / 115200); must be >= 2
//  STOP_BITS     1     number of stop bits (1 or 2)
//  PARITY_EN     0     1: append even-parity bit after data
//  FLOW_CTRL_EN  1     1: frame start gated by synchronised rts_n_i == 0
// PORTS
//  clk_i      in   1  fabric clock (BUFG'd reference clock)
//  rst_i      in   1  synchronous reset, active-high
//  data_i     in   8  byte to send
//  valid_i    in   1  data_i valid
//  ready_o    out  1  byte accepted on valid_i & ready_o at rising clk_i
//  rts_n_i    in   1  SoC RTS (async), 0 = SoC can receive
//  tx_o       out  1  serial line to SoC RX pad, idle high
//  busy_o     out  1  frame pending or in flight
// BEHAVIOUR
//  Reset (sync): tx_o=1, ready_o=1, busy_o=0, state IDLE, baud counter 0, RTS sync flops = 1.
//  rts_n_i passes through a 2-FF synchroniser (cts_ok = ~rts_sync); FLOW_CTRL_EN=0 forces cts_ok=1.
//  FSM states: IDLE, WAIT_CTS, START, DATA, PARITY, STOP.
//   IDLE: ready_o=1; on accept, latch byte; -> START if cts_ok else WAIT_CTS.
//   WAIT_CTS: tx_o=1, ready_o=0; -> START the cycle after cts_ok seen.
//   START: tx_o=0 for CLKS_PER_BIT cycles; -> DATA.
//   DATA: bits LSB first, CLKS_PER_BIT cycles each, 3-bit index 0..7; -> PARITY if PARITY_EN else STOP.
//   PARITY: tx_o = ^byte (even parity) for CLKS_PER_BIT cycles; -> STOP.
//   STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  tx_o registered; first start-bit cycle is the cycle after accept (or after WAIT_CTS exit).
//  Baud counter $clog2(CLKS_PER_BIT) bits, loads CLKS_PER_BIT-1, bit ends at 0; no drift, no fractional baud.
//  ready_o also high in final cycle of last stop bit: accept there -> START/WAIT_CTS directly,
//   zero idle gap between back-to-back frames; no accept -> IDLE.
//  busy_o = (state != IDLE).
//  cts_ok checked only at frame start; RTS deassert mid-frame does not abort or stretch the frame.
//  valid_i while ready_o=0 ignored; data_i needs to be stable only at the accept edge.
//  rst_i mid-frame: frame aborted, tx_o=1 the cycle after rst_i sampled high (line may show a short
//   spurious frame; SoC-side framing error acceptable).
//  rts_n_i toggling at accept: decision uses the synchronised value of that edge only.
// STRUCTURE
//  Package fpga_uart_pkg: state enum type, default CLKS_PER_BIT, parity enum.
//  Sub-module fpga_uart_baud_cnt: load/count-down/bit_done tick (reused by a future RX side).
//  Synchroniser: existing generic 2-FF sync cell, reset value 1.
// TESTING  (CLKS_PER_BIT=4 unless stated)
//  0x55, FLOW_CTRL_EN=0 -> tx_o 0,1,0,1,0,1,0,1,0,1 each 4 cycles; 40-cycle frame; ready_o in cycle 40.
//  rts_n_i=1, send 0xA3 -> tx_o held 1, busy_o=1; rts_n_i->0 -> tx_o low 3 cycles later; frame correct.
//  PARITY_EN=1, 0x07 -> parity bit 1; 0x03 -> 0; 44-cycle frame.
//  Back-to-back 0x01,0x80 with valid_i held -> 2nd start bit immediately after 1st stop; 80 cycles.
//  rts_n_i->1 during data bit 2 -> frame completes; next byte waits in WAIT_CTS.
//  rst_i pulse during data bit 3 -> tx_o=1 next cycle, ready_o=1, busy_o=0; next byte sent cleanly.

Source files
------------

// File: rtl/fpga_uart_pkg.sv
// Shared types and helpers for the fabric-side UART host transmitter.
package fpga_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 1085;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CTS = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_PARITY   = 3'd4,
        ST_STOP     = 3'd5
    } tx_state_t;

    typedef enum logic {
        PARITY_NONE = 1'b0,
        PARITY_EVEN = 1'b1
    } parity_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fpga_uart_baud_cnt.sv
// Bit-period down-counter: load restarts a period, done_o marks its final clock cycle.
module fpga_uart_baud_cnt #(
    parameter  int CLKS_PER_BIT = 4,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);

    logic [CNT_W-1:0] r_cnt;

    // load on request, otherwise count down and park at zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= CNT_W'(CLKS_PER_BIT - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt_o  = r_cnt;
    assign done_o = (r_cnt == '0);

endmodule

// File: rtl/fpga_uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level, with a settable reset value.
module fpga_uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/fpga_uart_host_tx.sv
// UART transmitter driving the SoC console RX pad from a valid/ready byte stream,
// with optional even parity and RTS-gated frame start.
module fpga_uart_host_tx
    import fpga_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int FLOW_CTRL_EN = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       rts_n_i,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int      CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam parity_t PARITY_MODE = (PARITY_EN != 0) ? PARITY_EVEN : PARITY_NONE;

    tx_state_t        r_state;
    logic [7:0]       r_byte;
    logic [2:0]       r_idx;
    logic             r_stop_idx;
    logic             r_tx;
    logic             r_ready;
    logic             r_busy;

    logic             w_rts_sync;
    logic             w_cts_ok;
    logic             w_accept;
    logic             w_load;
    logic             w_bit_done;
    logic             w_last_stop;
    logic [2:0]       w_next_idx;
    logic [CNT_W-1:0] w_cnt;

    fpga_uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rts_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rts_n_i),
        .q_o   (w_rts_sync)
    );

    // Counter is held loaded while waiting so a frame always starts with a full bit period.
    fpga_uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_load),
        .cnt_o  (w_cnt),
        .done_o (w_bit_done)
    );

    assign w_cts_ok    = (FLOW_CTRL_EN != 0) ? ~w_rts_sync : 1'b1;
    assign w_accept    = valid_i & r_ready;
    assign w_load      = w_bit_done | (r_state == ST_IDLE) | (r_state == ST_WAIT_CTS);
    assign w_last_stop = (STOP_BITS < 2) | r_stop_idx;
    assign w_next_idx  = r_idx + 3'd1;

    // frame sequencer with registered line, ready and busy outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_byte     <= 8'h00;
            r_idx      <= 3'd0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_byte  <= data_i;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_cts_ok) begin
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT_CTS;
                        end
                    end
                end
                ST_WAIT_CTS: begin
                    if (w_cts_ok) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_state <= ST_DATA;
                        r_idx   <= 3'd0;
                        r_tx    <= r_byte[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        if (r_idx == 3'd7) begin
                            r_stop_idx <= 1'b0;
                            if (PARITY_MODE == PARITY_EVEN) begin
                                r_state <= ST_PARITY;
                                r_tx    <= even_parity(r_byte);
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx <= w_next_idx;
                            r_tx  <= r_byte[w_next_idx];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_state    <= ST_STOP;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_done) begin
                        if (!w_last_stop) begin
                            r_stop_idx <= 1'b1;
                        end else if (w_accept) begin
                            // back-to-back byte: no idle gap between frames
                            r_byte  <= data_i;
                            r_ready <= 1'b0;
                            if (w_cts_ok) begin
                                r_state <= ST_START;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= ST_WAIT_CTS;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_last_stop && (w_cnt == CNT_W'(1))) begin
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o    = r_tx;
    assign ready_o = r_ready;
    assign busy_o  = r_busy;

endmodule

// File: tb/tb_fpga_uart_host_tx.sv
// Directed and randomized bench for fpga_uart_host_tx, checked against a bit-list frame model.
module tb_fpga_uart_host_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       rts_n;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    fpga_uart_host_tx #(
        .CLKS_PER_BIT (CPB), .STOP_BITS (1), .PARITY_EN (0), .FLOW_CTRL_EN (1)
    ) u_dut0 (
        .clk_i (clk), .rst_i (rst), .data_i (data0), .valid_i (valid0), .ready_o (ready0),
        .rts_n_i (rts_n), .tx_o (tx0), .busy_o (busy0)
    );

    fpga_uart_host_tx #(
        .CLKS_PER_BIT (CPB), .STOP_BITS (1), .PARITY_EN (1), .FLOW_CTRL_EN (0)
    ) u_dut1 (
        .clk_i (clk), .rst_i (rst), .data_i (data1), .valid_i (valid1), .ready_o (ready1),
        .rts_n_i (rts_n), .tx_o (tx1), .busy_o (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_tx(int w);
        return (w == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_ready(int w);
        return (w == 0) ? ready0 : ready1;
    endfunction

    function automatic logic get_busy(int w);
        return (w == 0) ? busy0 : busy1;
    endfunction

    task automatic set_in(int w, logic [7:0] d, logic v);
        if (w == 0) begin
            data0 = d; valid0 = v;
        end else begin
            data1 = d; valid1 = v;
        end
    endtask

    task automatic set_valid(int w, logic v);
        if (w == 0) valid0 = v;
        else        valid1 = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line levels, one entry per bit period: start, data LSB first, optional parity, stop.
    task automatic build_frame(input logic [7:0] b, input bit par, output logic [11:0] bits, output int nb);
        int ones;
        ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits[i + 1] = b[i];
            ones += int'(b[i]);
        end
        nb = 9;
        if (par) begin
            bits[nb] = ((ones % 2) == 1) ? 1'b1 : 1'b0;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
    endtask

    // Present a byte and wait (bounded) for the negedge at which ready is seen; accept is the next posedge.
    task automatic start_send(int w, logic [7:0] b);
        int n;
        @(negedge clk);
        set_in(w, b, 1'b1);
        n = 0;
        while (get_ready(w) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", n < 200, 1'b1);
    endtask

    // Check a whole frame cycle by cycle, starting at the negedge after the start-bit edge.
    task automatic run_frame(int w, logic [7:0] b, bit keep, logic [7:0] nxt, int rts_at, int rst_at);
        logic [11:0] bits;
        int          nb;
        logic        last;
        build_frame(b, (w == 1), bits, nb);
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                last = (k == nb - 1) && (c == CPB - 1);
                chk("tx_bit", get_tx(w), bits[k]);
                chk("busy_frame", get_busy(w), 1'b1);
                chk("ready_frame", get_ready(w), last);
                if (k == 0 && c == 0 && !keep) set_valid(w, 1'b0);
                if (k == rts_at && c == 0) rts_n = 1'b1;
                if (k == rst_at && c == 1) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_tx", get_tx(w), 1'b1);
                    chk("rst_ready", get_ready(w), 1'b1);
                    chk("rst_busy", get_busy(w), 1'b0);
                    return;
                end
                if (last && keep) set_in(w, nxt, 1'b1);
            end
        end
    endtask

    // Byte accepted with CTS not yet granted: line must hold idle until RTS falls, then start 3 edges later.
    task automatic cts_gated_frame(int w, logic [7:0] b, int hold);
        start_send(w, b);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            set_valid(w, 1'b0);
            chk("wait_tx", get_tx(w), 1'b1);
            chk("wait_busy", get_busy(w), 1'b1);
            chk("wait_ready", get_ready(w), 1'b0);
        end
        rts_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("cts_latency_tx", get_tx(w), 1'b1);
        end
        run_frame(w, b, 1'b0, 8'h00, -1, -1);
    endtask

    initial begin
        int          w;
        logic [7:0]  b;
        rst   = 1'b1;
        rts_n = 1'b0;
        data0 = 8'h00; valid0 = 1'b0;
        data1 = 8'h00; valid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx0", tx0, 1'b1);
        chk("reset_ready0", ready0, 1'b1);
        chk("reset_busy0", busy0, 1'b0);
        chk("reset_tx1", tx1, 1'b1);
        chk("reset_busy1", busy1, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // plain 8N1 frame
        start_send(0, 8'h55);
        run_frame(0, 8'h55, 1'b0, 8'h00, -1, -1);

        // flow control holds the frame until RTS is asserted
        rts_n = 1'b1;
        repeat (4) @(negedge clk);
        cts_gated_frame(0, 8'hA3, 4);

        // even parity
        start_send(1, 8'h07);
        run_frame(1, 8'h07, 1'b0, 8'h00, -1, -1);
        start_send(1, 8'h03);
        run_frame(1, 8'h03, 1'b0, 8'h00, -1, -1);

        // back-to-back frames with valid held
        start_send(0, 8'h01);
        run_frame(0, 8'h01, 1'b1, 8'h80, -1, -1);
        run_frame(0, 8'h80, 1'b0, 8'h00, -1, -1);

        // RTS deasserted during data bit 2: frame completes, next byte waits
        start_send(0, 8'h3C);
        run_frame(0, 8'h3C, 1'b0, 8'h00, 3, -1);
        cts_gated_frame(0, 8'hC5, 3);

        // reset during data bit 3, then a clean frame
        start_send(0, 8'h96);
        run_frame(0, 8'h96, 1'b0, 8'h00, -1, 4);
        repeat (4) @(negedge clk);
        start_send(0, 8'h69);
        run_frame(0, 8'h69, 1'b0, 8'h00, -1, -1);

        // randomized bytes on both configurations
        for (int i = 0; i < 10; i++) begin
            w = int'($urandom_range(0, 1));
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_send(w, b);
            run_frame(w, b, 1'b0, 8'h00, -1, -1);
        end

        @(negedge clk);
        chk("final_idle_busy0", busy0, 1'b0);
        chk("final_idle_tx1", tx1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
